// File: rtl/multicycle_control_fsm.sv
// multicycle_control_fsm
//
// Sequencing controller for a multi-cycle RISC-V core. It steps a shared
// single-ALU / single-memory datapath through the IF, ID, EX, MEM and WB
// phases. It decodes the opcode held in the IR, waits on the variable-latency
// memory handshake, and halts the core on a terminating ECALL.
//
// Ports
//   clk           in   clock; all state changes happen on the rising edge
//   reset         in   synchronous, active-high
//   part_of_inst  in   [6:0] opcode field of the IR
//   bcond         in   branch condition from the ALU (valid in EX)
//   halt_req      in   ECALL-terminates flag (sampled in ID)
//   mem_ready     in   memory completion (looked at only in IF and MEM)
//   pc_write      out  PC load enable
//   i_or_d        out  memory address select: 0 = PC, 1 = ALUOut
//   mem_read      out  memory read request
//   mem_write     out  memory write request
//   ir_write      out  IR load enable
//   mdr_write     out  MDR load enable
//   mem_to_reg    out  write-back select: 1 = MDR, 0 = ALUOut
//   reg_write     out  register-file write enable
//   alu_src_a     out  0 = PC, 1 = register A
//   alu_src_b     out  [1:0] 00 = B, 01 = constant 4, 10 = immediate
//   alu_op        out  [1:0] 00 = add, 01 = branch compare, 10 = funct
//   is_halted     out  core halted
//   inst_retired  out  one-cycle pulse when an instruction completes
//   state         out  [2:0] current state encoding (debug)
module multicycle_control_fsm (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] part_of_inst,
  input  logic       bcond,
  input  logic       halt_req,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       mdr_write,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic       is_halted,
  output logic       inst_retired,
  output logic [2:0] state
);

  localparam logic [6:0] OP_LOAD           = 7'b0000011;
  localparam logic [6:0] OP_STORE          = 7'b0100011;
  localparam logic [6:0] OP_ARITHMETIC     = 7'b0110011;
  localparam logic [6:0] OP_ARITHMETIC_IMM = 7'b0010011;
  localparam logic [6:0] OP_BRANCH         = 7'b1100011;
  localparam logic [6:0] OP_ECALL          = 7'b1110011;

  typedef enum logic [2:0] {
    S_IF       = 3'd0,
    S_ID       = 3'd1,
    S_EX       = 3'd2,
    S_MEM      = 3'd3,
    S_WB       = 3'd4,
    S_PC_UPD   = 3'd5,
    S_BR_TAKEN = 3'd6,
    S_HALT     = 3'd7
  } state_e;

  state_e state_q, state_d;

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IF;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d      = state_q;
    pc_write     = 1'b0;
    i_or_d       = 1'b0;
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    ir_write     = 1'b0;
    mdr_write    = 1'b0;
    mem_to_reg   = 1'b0;
    reg_write    = 1'b0;
    alu_src_a    = 1'b0;
    alu_src_b    = 2'b00;
    alu_op       = 2'b00;
    is_halted    = 1'b0;
    inst_retired = 1'b0;

    case (state_q)
      S_IF: begin
        mem_read = 1'b1;
        ir_write = mem_ready;
        if (mem_ready) state_d = S_ID;
      end
      S_ID: begin
        case (part_of_inst)
          OP_ECALL:          state_d = halt_req ? S_HALT : S_PC_UPD;
          OP_LOAD, OP_STORE, OP_ARITHMETIC,
          OP_ARITHMETIC_IMM, OP_BRANCH:
                             state_d = S_EX;
          default:           state_d = S_PC_UPD;  // unknown opcode retires as a NOP
        endcase
      end
      S_EX: begin
        alu_src_a = 1'b1;
        case (part_of_inst)
          OP_ARITHMETIC: begin
            alu_op  = 2'b10;
            state_d = S_WB;
          end
          OP_ARITHMETIC_IMM: begin
            alu_src_b = 2'b10;
            alu_op    = 2'b10;
            state_d   = S_WB;
          end
          OP_LOAD, OP_STORE: begin
            alu_src_b = 2'b10;
            state_d   = S_MEM;
          end
          OP_BRANCH: begin
            alu_op  = 2'b01;
            state_d = bcond ? S_BR_TAKEN : S_PC_UPD;
          end
          default: state_d = S_PC_UPD;  // unreachable: ID only sends the above here
        endcase
      end
      S_MEM: begin
        // Address and request stay constant until the memory answers.
        i_or_d = 1'b1;
        if (part_of_inst == OP_LOAD) begin
          mem_read  = 1'b1;
          mdr_write = mem_ready;
          if (mem_ready) state_d = S_WB;
        end else begin
          mem_write = 1'b1;
          if (mem_ready) state_d = S_PC_UPD;
        end
      end
      S_WB: begin
        // The register write and the PC+4 update share this cycle.
        reg_write    = 1'b1;
        mem_to_reg   = (part_of_inst == OP_LOAD);
        alu_src_b    = 2'b01;
        pc_write     = 1'b1;
        inst_retired = 1'b1;
        state_d      = S_IF;
      end
      S_PC_UPD: begin
        alu_src_b    = 2'b01;
        pc_write     = 1'b1;
        inst_retired = 1'b1;
        state_d      = S_IF;
      end
      S_BR_TAKEN: begin
        alu_src_b    = 2'b10;
        pc_write     = 1'b1;
        inst_retired = 1'b1;
        state_d      = S_IF;
      end
      S_HALT: begin
        is_halted = 1'b1;
      end
    endcase

    state = state_q;

    // Reset masks the outputs in the same cycle, so an access that is
    // in flight is dropped immediately and not one edge later.
    if (reset) begin
      pc_write     = 1'b0;
      i_or_d       = 1'b0;
      mem_read     = 1'b0;
      mem_write    = 1'b0;
      ir_write     = 1'b0;
      mdr_write    = 1'b0;
      mem_to_reg   = 1'b0;
      reg_write    = 1'b0;
      alu_src_a    = 1'b0;
      alu_src_b    = 2'b00;
      alu_op       = 2'b00;
      is_halted    = 1'b0;
      inst_retired = 1'b0;
      state        = 3'd0;
    end
  end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
module tb_multicycle_control_fsm;

  localparam logic [6:0] LOAD  = 7'b0000011;
  localparam logic [6:0] STORE = 7'b0100011;
  localparam logic [6:0] ARITH = 7'b0110011;
  localparam logic [6:0] ARIMM = 7'b0010011;
  localparam logic [6:0] BRAN  = 7'b1100011;
  localparam logic [6:0] ECALL = 7'b1110011;
  localparam logic [6:0] UNDEF = 7'b1111111;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] part_of_inst;
  logic       bcond, halt_req, mem_ready;
  logic       pc_write, i_or_d, mem_read, mem_write, ir_write, mdr_write;
  logic       mem_to_reg, reg_write, alu_src_a, is_halted, inst_retired;
  logic [1:0] alu_src_b, alu_op;
  logic [2:0] state;

  always #5 clk = ~clk;

  multicycle_control_fsm dut (
    .clk(clk), .reset(reset), .part_of_inst(part_of_inst), .bcond(bcond),
    .halt_req(halt_req), .mem_ready(mem_ready), .pc_write(pc_write),
    .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write),
    .ir_write(ir_write), .mdr_write(mdr_write), .mem_to_reg(mem_to_reg),
    .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .is_halted(is_halted), .inst_retired(inst_retired),
    .state(state)
  );

  // Expected output word:
  // {state, pc_write, i_or_d, mem_read, mem_write, ir_write, mdr_write,
  //  mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op, is_halted, inst_retired}
  function automatic logic [17:0] mk(input logic [2:0] st, input logic pcw,
      input logic iod, input logic mr, input logic mw, input logic irw,
      input logic mdw, input logic m2r, input logic rw, input logic a,
      input logic [1:0] b, input logic [1:0] op, input logic h, input logic ret);
    return {st, pcw, iod, mr, mw, irw, mdw, m2r, rw, a, b, op, h, ret};
  endfunction

  typedef struct {
    logic        rst;
    logic [6:0]  op;
    logic        bc;
    logic        hr;
    logic        rdy;
    logic [17:0] exp;
  } vec_t;

  vec_t vecs[$];
  int   total = 0;
  int   bad   = 0;

  logic [17:0] E_RST, E_IF_W, E_IF_R, E_ID, E_EX_R, E_EX_I, E_EX_M, E_EX_B;
  logic [17:0] E_MEM_LW, E_MEM_LR, E_MEM_S, E_WB_R, E_WB_L, E_PCU, E_BRT, E_HALT;

  function automatic logic [17:0] actual();
    return {state, pc_write, i_or_d, mem_read, mem_write, ir_write, mdr_write,
            mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op, is_halted,
            inst_retired};
  endfunction

  task automatic add(input logic r, input logic [6:0] o, input logic bc,
                     input logic hr, input logic rdy, input logic [17:0] e);
    vec_t v;
    v.rst = r; v.op = o; v.bc = bc; v.hr = hr; v.rdy = rdy; v.exp = e;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic r, input logic [6:0] o, input logic bc,
                       input logic hr, input logic rdy);
    @(negedge clk);
    reset = r; part_of_inst = o; bcond = bc; halt_req = hr; mem_ready = rdy;
  endtask

  task automatic chk(input string nm, input logic [17:0] e);
    logic [17:0] a;
    #1;
    a = actual();
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got=%05h want=%05h", nm, a, e);
    end
  endtask

  initial begin
    int n;
    reset = 1'b1; part_of_inst = '0; bcond = 1'b0; halt_req = 1'b0; mem_ready = 1'b0;

    E_RST    = mk(3'd0, 0,0,0,0,0,0,0,0, 0, 2'b00, 2'b00, 0,0);
    E_IF_W   = mk(3'd0, 0,0,1,0,0,0,0,0, 0, 2'b00, 2'b00, 0,0);
    E_IF_R   = mk(3'd0, 0,0,1,0,1,0,0,0, 0, 2'b00, 2'b00, 0,0);
    E_ID     = mk(3'd1, 0,0,0,0,0,0,0,0, 0, 2'b00, 2'b00, 0,0);
    E_EX_R   = mk(3'd2, 0,0,0,0,0,0,0,0, 1, 2'b00, 2'b10, 0,0);
    E_EX_I   = mk(3'd2, 0,0,0,0,0,0,0,0, 1, 2'b10, 2'b10, 0,0);
    E_EX_M   = mk(3'd2, 0,0,0,0,0,0,0,0, 1, 2'b10, 2'b00, 0,0);
    E_EX_B   = mk(3'd2, 0,0,0,0,0,0,0,0, 1, 2'b00, 2'b01, 0,0);
    E_MEM_LW = mk(3'd3, 0,1,1,0,0,0,0,0, 0, 2'b00, 2'b00, 0,0);
    E_MEM_LR = mk(3'd3, 0,1,1,0,0,1,0,0, 0, 2'b00, 2'b00, 0,0);
    E_MEM_S  = mk(3'd3, 0,1,0,1,0,0,0,0, 0, 2'b00, 2'b00, 0,0);
    E_WB_R   = mk(3'd4, 1,0,0,0,0,0,0,1, 0, 2'b01, 2'b00, 0,1);
    E_WB_L   = mk(3'd4, 1,0,0,0,0,0,1,1, 0, 2'b01, 2'b00, 0,1);
    E_PCU    = mk(3'd5, 1,0,0,0,0,0,0,0, 0, 2'b01, 2'b00, 0,1);
    E_BRT    = mk(3'd6, 1,0,0,0,0,0,0,0, 0, 2'b10, 2'b00, 0,1);
    E_HALT   = mk(3'd7, 0,0,0,0,0,0,0,0, 0, 2'b00, 2'b00, 1,0);

    // reset, outputs masked
    add(1, ARITH, 0,0,1, E_RST);
    add(1, ARITH, 0,0,1, E_RST);
    // ARITHMETIC, zero-wait: 0,1,2,4
    add(0, ARITH, 0,0,1, E_IF_R);
    add(0, ARITH, 0,0,1, E_ID);
    add(0, ARITH, 0,0,1, E_EX_R);
    add(0, ARITH, 0,0,1, E_WB_R);
    // LOAD: 3 IF waits, 2 MEM waits; mem_ready high in ID/EX is ignored
    add(0, LOAD, 0,0,0, E_IF_W);
    add(0, LOAD, 0,0,0, E_IF_W);
    add(0, LOAD, 0,0,0, E_IF_W);
    add(0, LOAD, 0,0,1, E_IF_R);
    add(0, LOAD, 0,0,1, E_ID);
    add(0, LOAD, 0,0,1, E_EX_M);
    add(0, LOAD, 0,0,0, E_MEM_LW);
    add(0, LOAD, 0,0,0, E_MEM_LW);
    add(0, LOAD, 0,0,1, E_MEM_LR);
    add(0, LOAD, 0,0,1, E_WB_L);
    // STORE, zero-wait: 0,1,2,3,5
    add(0, STORE, 0,0,1, E_IF_R);
    add(0, STORE, 0,0,1, E_ID);
    add(0, STORE, 0,0,1, E_EX_M);
    add(0, STORE, 0,0,1, E_MEM_S);
    add(0, STORE, 0,0,1, E_PCU);
    // BRANCH taken
    add(0, BRAN, 1,0,1, E_IF_R);
    add(0, BRAN, 1,0,1, E_ID);
    add(0, BRAN, 1,0,1, E_EX_B);
    add(0, BRAN, 1,0,1, E_BRT);
    // BRANCH not taken
    add(0, BRAN, 0,0,1, E_IF_R);
    add(0, BRAN, 0,0,1, E_ID);
    add(0, BRAN, 0,0,1, E_EX_B);
    add(0, BRAN, 0,0,1, E_PCU);
    // ARITHMETIC_IMM
    add(0, ARIMM, 0,0,1, E_IF_R);
    add(0, ARIMM, 0,0,1, E_ID);
    add(0, ARIMM, 0,0,1, E_EX_I);
    add(0, ARIMM, 0,0,1, E_WB_R);
    // non-halting ECALL
    add(0, ECALL, 0,0,1, E_IF_R);
    add(0, ECALL, 0,0,1, E_ID);
    add(0, ECALL, 0,0,1, E_PCU);
    // undefined opcode is a NOP
    add(0, UNDEF, 0,0,1, E_IF_R);
    add(0, UNDEF, 0,0,1, E_ID);
    add(0, UNDEF, 0,0,1, E_PCU);
    // STORE aborted by reset while waiting in MEM
    add(0, STORE, 0,0,1, E_IF_R);
    add(0, STORE, 0,0,1, E_ID);
    add(0, STORE, 0,0,1, E_EX_M);
    add(0, STORE, 0,0,0, E_MEM_S);
    add(1, STORE, 0,0,0, E_RST);
    add(0, STORE, 0,0,0, E_IF_W);

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].op, vecs[i].bc, vecs[i].hr, vecs[i].rdy);
      chk($sformatf("vec%0d", i), vecs[i].exp);
    end

    // ARITHMETIC latency from the ready fetch until the retire pulse
    n = 0;
    do begin
      drive(0, ARITH, 0, 0, 1);
      #1;
      n++;
    end while (!inst_retired && n < 20);
    total++;
    if (!inst_retired || n != 4) begin
      bad++;
      $display("FAIL arith_latency: got=%0d cycles want=4", n);
    end

    // Halting ECALL, HALT absorbs arbitrary inputs, reset leaves it
    drive(0, ECALL, 0, 1, 1); chk("halt_if", E_IF_R);
    drive(0, ECALL, 0, 1, 1); chk("halt_id", E_ID);
    for (int k = 0; k < 24; k++) begin
      drive(0, 7'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      chk($sformatf("halt_hold%0d", k), E_HALT);
    end
    drive(1, ECALL, 0, 1, 1); chk("halt_reset", E_RST);
    drive(0, ARITH, 0, 0, 0); chk("after_halt_reset", E_IF_W);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
